// File: rtl/rom_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : rom_dump_reader_if
// Brief    : Command, ROM read port and TX byte bus for rom_dump_reader.
// Revision : 1.0 - initial release
// ============================================================================
interface rom_dump_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [15:0]       i_word_count;
  logic [ADDR_W-1:0] o_rom_addr;
  logic              o_rom_rd;
  logic [DATA_W-1:0] i_rom_data;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              i_tx_ready;
  logic              o_busy;
  logic              o_done;

  // slave = the dump engine, master = system side (ROM, UART, boot control)
  modport slave (
    input  i_start, i_base_addr, i_word_count, i_rom_data, i_tx_ready,
    output o_rom_addr, o_rom_rd, o_tx_data, o_tx_valid, o_busy, o_done
  );

  modport master (
    output i_start, i_base_addr, i_word_count, i_rom_data, i_tx_ready,
    input  o_rom_addr, o_rom_rd, o_tx_data, o_tx_valid, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/rom_dump_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_dump_reader
// Brief    : Reads a ROM range and streams each word as two bytes (high
//            first) to the UART TX. Optional trailing 16-bit checksum when
//            ROM_DUMP_CHECKSUM_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module rom_dump_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  wire                     clk,
  input  wire                     i_reset_n,
  rom_dump_reader_if.slave        bus
);

`ifdef ROM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND_HI = 3'd3,
    S_SEND_LO = 3'd4,
    S_CSUM_HI = 3'd5,
    S_CSUM_LO = 3'd6,
    S_FINISH  = 3'd7
  } state_t;
  localparam state_t S_TAIL = S_CSUM_HI;
`else
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_READ    = 3'd1,
    S_CAPTURE = 3'd2,
    S_SEND_HI = 3'd3,
    S_SEND_LO = 3'd4,
    S_FINISH  = 3'd7
  } state_t;
  localparam state_t S_TAIL = S_FINISH;
`endif

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_count;
  logic [15:0]       r_word;
  logic              w_handshake;
  logic              w_last_word;
  logic              w_tx_valid;
  logic [7:0]        w_tx_data;

  assign w_handshake = w_tx_valid && bus.i_tx_ready;
  assign w_last_word = (r_count == 16'd1);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_start) begin
          w_next_state = (bus.i_word_count == 16'd0) ? S_TAIL : S_READ;
        end
      end
      S_READ:    w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_SEND_HI;
      S_SEND_HI: if (w_handshake) w_next_state = S_SEND_LO;
      S_SEND_LO: if (w_handshake) w_next_state = w_last_word ? S_TAIL : S_READ;
`ifdef ROM_DUMP_CHECKSUM_EN
      S_CSUM_HI: if (w_handshake) w_next_state = S_CSUM_LO;
      S_CSUM_LO: if (w_handshake) w_next_state = S_FINISH;
`endif
      S_FINISH:  w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // Address and count advance on the low-byte handshake; both wrap mod 2^16.
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_addr  <= '0;
      r_count <= '0;
      r_word  <= '0;
    end else begin
      if (r_state == S_IDLE && bus.i_start) begin
        r_addr  <= bus.i_base_addr;
        r_count <= bus.i_word_count;
      end
      if (r_state == S_CAPTURE) begin
        r_word <= bus.i_rom_data[15:0];
      end
      if (r_state == S_SEND_LO && w_handshake) begin
        r_addr  <= r_addr + 1'b1;
        r_count <= r_count - 16'd1;
      end
    end
  end

`ifdef ROM_DUMP_CHECKSUM_EN
  logic [15:0] r_csum;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_csum <= '0;
    end else if (r_state == S_IDLE && bus.i_start) begin
      r_csum <= '0;
    end else if (r_state == S_CAPTURE) begin
      r_csum <= r_csum + bus.i_rom_data[15:0];
    end
  end
`endif

  // Byte mux depends only on state and registers, so data is stable while stalled.
  always_comb begin
    w_tx_valid = 1'b0;
    w_tx_data  = 8'h00;
    case (r_state)
      S_SEND_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_word[15:8];
      end
      S_SEND_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_word[7:0];
      end
`ifdef ROM_DUMP_CHECKSUM_EN
      S_CSUM_HI: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_csum[15:8];
      end
      S_CSUM_LO: begin
        w_tx_valid = 1'b1;
        w_tx_data  = r_csum[7:0];
      end
`endif
      default: begin
        w_tx_valid = 1'b0;
        w_tx_data  = 8'h00;
      end
    endcase
  end

  assign bus.o_rom_addr = r_addr;
  assign bus.o_rom_rd   = (r_state == S_READ);
  assign bus.o_tx_data  = w_tx_data;
  assign bus.o_tx_valid = w_tx_valid;
  assign bus.o_busy     = (r_state != S_IDLE);
  assign bus.o_done     = (r_state == S_FINISH);

endmodule
`default_nettype wire
